// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPU between NUM_REQ APU requesters with an in-order ID FIFO.
// Define FPU_ARB_PERF_EN to add per-requester grant/stall performance counters.
module fpu_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int C_OP         = 32,
    parameter int C_CMD        = 4,
    parameter int C_RM         = 3,
    parameter int C_TAG        = 4,
    parameter int C_FLAG       = 5
) (
    input  logic                             Clk_CI,
    input  logic                             Rst_RBI,
    input  logic [NUM_REQ-1:0]               Req_Valid_SI,
    output logic [NUM_REQ-1:0]               Req_Ready_SO,
    input  logic [NUM_REQ-1:0][C_OP-1:0]     Req_ArgA_DI,
    input  logic [NUM_REQ-1:0][C_OP-1:0]     Req_ArgB_DI,
    input  logic [NUM_REQ-1:0][C_CMD-1:0]    Req_Op_DI,
    input  logic [NUM_REQ-1:0][C_RM-1:0]     Req_RM_DI,
    input  logic [NUM_REQ-1:0][C_TAG-1:0]    Req_Tag_DI,
    output logic [NUM_REQ-1:0]               Resp_Valid_SO,
    output logic [C_OP-1:0]                  Resp_Result_DO,
    output logic [C_FLAG-1:0]                Resp_Flags_DO,
    output logic [C_TAG-1:0]                 Resp_Tag_DO,
    output logic                             Fpu_Valid_SO,
    output logic [C_OP-1:0]                  Fpu_ArgA_DO,
    output logic [C_OP-1:0]                  Fpu_ArgB_DO,
    output logic [C_CMD-1:0]                 Fpu_Op_DO,
    output logic [C_RM-1:0]                  Fpu_RM_DO,
    output logic [C_TAG-1:0]                 Fpu_Tag_DO,
    input  logic                             Fpu_Ready_SI,
    input  logic                             Fpu_Req_SI,
    input  logic [C_OP-1:0]                  Fpu_Result_DI,
    input  logic [C_FLAG-1:0]                Fpu_Flags_DI,
    input  logic [C_TAG-1:0]                 Fpu_Tag_DI,
`ifdef FPU_ARB_PERF_EN
    output logic                             Err_SO,
    input  logic                             Perf_Clear_SI,
    output logic [NUM_REQ-1:0][31:0]         Perf_Grant_DO,
    output logic [NUM_REQ-1:0][31:0]         Perf_Stall_DO
`else
    output logic                             Err_SO
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PW   = $clog2(MAX_INFLIGHT);

    logic [ID_W-1:0] ptr, gnt_id, head;
    logic [ID_W:0]   idx;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0] fifo [MAX_INFLIGHT];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            pop, push, can_issue, found;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept a grant.
    always_comb begin
        pop       = Fpu_Req_SI && count != '0;
        can_issue = Fpu_Ready_SI && (count != (PW+1)'(MAX_INFLIGHT) || pop);
        found     = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (can_issue && !found && Req_Valid_SI[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
        grant = found ? NUM_REQ'(1) << gnt_id : '0;
        push  = found;
    end

    assign Req_Ready_SO = grant;
    assign head         = fifo[rd_ptr];

    always_ff @(posedge Clk_CI)
        if (push)
            fifo[wr_ptr] <= gnt_id;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            Fpu_Valid_SO   <= 1'b0;
            Fpu_ArgA_DO    <= '0;
            Fpu_ArgB_DO    <= '0;
            Fpu_Op_DO      <= '0;
            Fpu_RM_DO      <= '0;
            Fpu_Tag_DO     <= '0;
            Resp_Valid_SO  <= '0;
            Resp_Result_DO <= '0;
            Resp_Flags_DO  <= '0;
            Resp_Tag_DO    <= '0;
            Err_SO         <= 1'b0;
        end else begin
            Fpu_Valid_SO <= push;
            if (push) begin
                ptr         <= gnt_id == ID_W'(NUM_REQ-1) ? '0 : gnt_id + 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
                Fpu_ArgA_DO <= Req_ArgA_DI[gnt_id];
                Fpu_ArgB_DO <= Req_ArgB_DI[gnt_id];
                Fpu_Op_DO   <= Req_Op_DI[gnt_id];
                Fpu_RM_DO   <= Req_RM_DI[gnt_id];
                Fpu_Tag_DO  <= Req_Tag_DI[gnt_id];
            end
            Resp_Valid_SO <= pop ? NUM_REQ'(1) << head : '0;
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                Resp_Result_DO <= Fpu_Result_DI;
                Resp_Flags_DO  <= Fpu_Flags_DI;
                Resp_Tag_DO    <= Fpu_Tag_DI;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (Fpu_Req_SI && count == '0)
                Err_SO <= 1'b1;
        end
    end

`ifdef FPU_ARB_PERF_EN
    // Saturating counters; clear takes priority over any increment.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Perf_Grant_DO <= '0;
            Perf_Stall_DO <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (Perf_Clear_SI) begin
                    Perf_Grant_DO[i] <= '0;
                    Perf_Stall_DO[i] <= '0;
                end else begin
                    if (grant[i] && !(&Perf_Grant_DO[i]))
                        Perf_Grant_DO[i] <= Perf_Grant_DO[i] + 32'd1;
                    if (Req_Valid_SI[i] && !grant[i] && !(&Perf_Stall_DO[i]))
                        Perf_Stall_DO[i] <= Perf_Stall_DO[i] + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed checks of grant order, issue/response latency, FIFO back-pressure and error flag.
// Perf counter checks are compiled in when FPU_ARB_PERF_EN is defined.
module tb_fpu_arbiter;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_ready;
    logic [3:0][31:0] req_arg_a = '0;
    logic [3:0][31:0] req_arg_b = '0;
    logic [3:0][3:0]  req_op = '0;
    logic [3:0][2:0]  req_rm = '0;
    logic [3:0][3:0]  req_tag = '0;
    logic [3:0]       resp_valid;
    logic [31:0]      resp_result;
    logic [4:0]       resp_flags;
    logic [3:0]       resp_tag;
    logic             fpu_valid;
    logic [31:0]      fpu_arg_a, fpu_arg_b;
    logic [3:0]       fpu_op;
    logic [2:0]       fpu_rm;
    logic [3:0]       fpu_tag;
    logic             fpu_ready = 1'b0;
    logic             fpu_req = 1'b0;
    logic [31:0]      fpu_result = '0;
    logic [4:0]       fpu_flags = '0;
    logic [3:0]       fpu_tag_in = '0;
    logic             err;
    int               checks = 0;
    int               failures = 0;
`ifdef FPU_ARB_PERF_EN
    logic             perf_clear = 1'b0;
    logic [3:0][31:0] perf_grant, perf_stall;
`endif

    always #5 clk = ~clk;

    fpu_arbiter dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req_Valid_SI(req_valid), .Req_Ready_SO(req_ready),
        .Req_ArgA_DI(req_arg_a), .Req_ArgB_DI(req_arg_b), .Req_Op_DI(req_op),
        .Req_RM_DI(req_rm), .Req_Tag_DI(req_tag),
        .Resp_Valid_SO(resp_valid), .Resp_Result_DO(resp_result),
        .Resp_Flags_DO(resp_flags), .Resp_Tag_DO(resp_tag),
        .Fpu_Valid_SO(fpu_valid), .Fpu_ArgA_DO(fpu_arg_a), .Fpu_ArgB_DO(fpu_arg_b),
        .Fpu_Op_DO(fpu_op), .Fpu_RM_DO(fpu_rm), .Fpu_Tag_DO(fpu_tag),
        .Fpu_Ready_SI(fpu_ready), .Fpu_Req_SI(fpu_req), .Fpu_Result_DI(fpu_result),
        .Fpu_Flags_DI(fpu_flags), .Fpu_Tag_DI(fpu_tag_in),
`ifdef FPU_ARB_PERF_EN
        .Err_SO(err), .Perf_Clear_SI(perf_clear),
        .Perf_Grant_DO(perf_grant), .Perf_Stall_DO(perf_stall)
`else
        .Err_SO(err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        fpu_req   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fpu_return(input int gap, input logic [3:0] t, input logic [3:0] exp_oh);
        repeat (gap) @(negedge clk);
        fpu_req    = 1'b1;
        fpu_result = 32'h1000 + 32'(t);
        fpu_tag_in = t;
        @(negedge clk);
        fpu_req = 1'b0;
        #1;
        check("ret_valid", 64'(resp_valid), 64'(exp_oh));
        check("ret_result", 64'(resp_result), 64'h1000 + 64'(t));
        check("ret_tag", 64'(resp_tag), 64'(t));
    endtask

    initial begin
        logic [3:0] e;
        repeat (2) @(negedge clk);
        #1;
        check("rst_fpu_valid", 64'(fpu_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_fpu_arg_a", 64'(fpu_arg_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: lone requester 1
        @(negedge clk);
        fpu_ready    = 1'b1;
        req_valid    = 4'b0010;
        req_arg_a[1] = 32'h3F800000;
        req_tag[1]   = 4'd5;
        req_op[1]    = 4'd3;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_fpu_valid", 64'(fpu_valid), 64'd1);
        check("t1_fpu_arg_a", 64'(fpu_arg_a), 64'h3F800000);
        check("t1_fpu_tag", 64'(fpu_tag), 64'd5);
        check("t1_fpu_op", 64'(fpu_op), 64'd3);
        @(negedge clk);
        #1;
        check("t1_fpu_valid_drop", 64'(fpu_valid), 64'd0);
        check("t1_arg_hold", 64'(fpu_arg_a), 64'h3F800000);
        fpu_req    = 1'b1;
        fpu_result = 32'h40000000;
        fpu_flags  = 5'h01;
        fpu_tag_in = 4'd5;
        @(negedge clk);
        fpu_req = 1'b0;
        #1;
        check("t1_resp_valid", 64'(resp_valid), 64'b0010);
        check("t1_resp_result", 64'(resp_result), 64'h40000000);
        check("t1_resp_flags", 64'(resp_flags), 64'h01);
        check("t1_resp_tag", 64'(resp_tag), 64'd5);
        @(negedge clk);
        #1;
        check("t1_resp_strobe", 64'(resp_valid), 64'd0);
        check("t1_resp_hold", 64'(resp_result), 64'h40000000);

        // Test 2: all valid, round-robin order with one return per cycle
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            fpu_req = (k > 0);
            #1;
            e = 4'b0001 << (k % 4);
            check("t2_grant", 64'(req_ready), 64'(e));
            if (k >= 2) begin
                e = 4'b0001 << ((k - 2) % 4);
                check("t2_resp", 64'(resp_valid), 64'(e));
            end
            @(negedge clk);
        end
        fpu_req   = 1'b0;
        req_valid = '0;
        #1;
        check("t2_err", 64'(err), 64'd0);

        // Test 3: FIFO full back-pressure, pop lets one more through
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_grant", 64'(req_ready), 64'b0001);
            @(negedge clk);
        end
        #1;
        check("t3_full_block", 64'(req_ready), 64'd0);
        fpu_req = 1'b1;
        #1;
        check("t3_pop_grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        fpu_req = 1'b0;
        #1;
        check("t3_still_full", 64'(req_ready), 64'd0);
        check("t3_resp", 64'(resp_valid), 64'b0001);
        check("t3_issue", 64'(fpu_valid), 64'd1);
        @(negedge clk);
        #1;
        check("t3_no_issue", 64'(fpu_valid), 64'd0);
        req_valid = '0;

        // Test 4: issue 2,0,3 then in-order returns with gaps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_tag[i]   = 4'(i + 8);
            req_arg_a[i] = 32'hA0 + 32'(i);
        end
        req_valid = 4'b0100;
        #1;
        check("t4_grant2", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("t4_grant0", 64'(req_ready), 64'b0001);
        check("t4_tag2", 64'(fpu_tag), 64'd10);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        check("t4_grant3", 64'(req_ready), 64'b1000);
        check("t4_tag0", 64'(fpu_tag), 64'd8);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t4_tag3", 64'(fpu_tag), 64'd11);
        check("t4_arg3", 64'(fpu_arg_a), 64'hA3);
        fpu_return(1, 4'd10, 4'b0100);
        fpu_return(0, 4'd8, 4'b0001);
        fpu_return(2, 4'd11, 4'b1000);
        check("t4_err", 64'(err), 64'd0);

        // Test 5: return with nothing in flight
        do_reset();
        #1;
        check("t5_err_clear", 64'(err), 64'd0);
        fpu_req = 1'b1;
        @(negedge clk);
        fpu_req = 1'b0;
        #1;
        check("t5_err_set", 64'(err), 64'd1);
        check("t5_no_resp", 64'(resp_valid), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t5_err_sticky", 64'(err), 64'd1);
        do_reset();
        #1;
        check("t5_err_reset", 64'(err), 64'd0);

`ifdef FPU_ARB_PERF_EN
        // Test 6: requester 3 stalls 3 cycles then is granted
        do_reset();
        fpu_ready = 1'b0;
        req_valid = 4'b1000;
        repeat (3) @(negedge clk);
        fpu_ready = 1'b1;
        #1;
        check("t6_grant", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t6_stall", 64'(perf_stall[3]), 64'd3);
        check("t6_grants", 64'(perf_grant[3]), 64'd1);
        perf_clear = 1'b1;
        @(negedge clk);
        perf_clear = 1'b0;
        #1;
        check("t6_stall_clr", 64'(perf_stall[3]), 64'd0);
        check("t6_grant_clr", 64'(perf_grant[3]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
